axis_rgb_unpacker: RTL and testbench
====================================

# axis_rgb_unpacker

Converts a 32-bit AXI4-Stream of packed 24-bit pixels back into one-pixel-per-beat r/g/b with sof/eol flags. It is the read-side counterpart of the RGB packer: it sits after the DMA/VDMA read channel and feeds the per-pixel CNN front end. Every 3 input words yield 4 pixels. Per-pixel byte order in the stream is G,B,R, starting at byte lane 0.

## Interface
- No parameters.
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous reset, active-high.
- s_axis_tdata  in  32  packed bytes; lane 0 = bits 7:0.
- s_axis_tvalid  in  1  input word valid.
- s_axis_tready  out  1  input word accepted when high with tvalid.
- s_axis_tlast  in  1  last word of line.
- s_axis_tuser  in  1  start of frame; marks first word of frame.
- r, g, b  out  8 each  pixel colour.
- out_valid  out  1  pixel valid.
- out_ready  in  1  consumer accepts pixel.
- sof  out  1  pixel is first of frame.
- eol  out  1  pixel is last of line.
- err_short_line  out  1  one-cycle pulse: tlast on word 0 or 1 of a group.
- err_sof_resync  out  1  one-cycle pulse: tuser on a word not at group start.

## Operation
- 2-bit phase register PH0..PH3 = pixel index within 4-pixel group; 24-bit residual register res[23:0] holds leftover bytes (lane order preserved); 1-bit last_reg, 1-bit sof_pend.
- Effective phase = PH0 when s_axis_tvalid & s_axis_tuser, else phase register.
- PH0: pixel = {g,b,r} = lanes 0,1,2 of input; on accept, res[7:0] <= lane 3; sof = s_axis_tuser.
- PH1: g = res[7:0], b = lane 0, r = lane 1; on accept, res[15:0] <= lanes 2,3.
- PH2: g = res[7:0], b = res[15:8], r = lane 0; on accept, res[23:0] <= lanes 1..3, last_reg <= s_axis_tlast.
- PH3: g,b,r = res[7:0], res[15:8], res[23:16]; eol = last_reg; no input consumed.
- Phase advances by one (wrapping PH3->PH0) on out_valid & out_ready.
- Phases 0-2: out_valid = s_axis_tvalid, s_axis_tready = out_ready; input word and output pixel transfer in the same cycle. PH3: out_valid = 1, s_axis_tready = 0.
- eol = 0 in PH0/PH1/PH2 except short-line case.
- Short line: tlast accepted in PH0 or PH1 -> that pixel has eol = 1, phase returns to PH0, residual discarded, err_short_line pulses next cycle.
- tlast in PH2 is normal: flag carried to PH3 pixel.
- SOF resync: tuser with tvalid while phase register != PH0 -> word decoded as PH0, residual and last_reg discarded, err_sof_resync pulses next cycle on acceptance.
- sof output only when effective phase is PH0 and tuser set; never asserted in PH3.

## Timing
- Reset values: phase = PH0, res = 0, last_reg = 0, err pulses = 0. While areset high: s_axis_tready = 0, out_valid = 0, sof = 0, eol = 0; r/g/b driven but don't care.
- Latency PH0-PH2: 0 cycles (combinational tdata -> r/g/b). PH3: registered, 1 cycle after PH2 acceptance at earliest.
- Throughput: 4 pixels per 4 cycles at full rate (input idles one cycle in 4).
- out_valid in PH0-PH2 may drop if tvalid drops; in PH3 held until accepted. Outputs stable while out_valid & !out_ready in PH3.
- Reset mid-group: phase and residual cleared; partial group lost, no pixel emitted.
- tkeep is not carried; line widths are multiples of 4 pixels.

## Structure
- Shared video package: phase localparams PH0..PH3, byte-lane constants for G,B,R order, pixel width 8. Same constants used by packer testbench.
- Single module, no sub-module; one registered process, one combinational decode case on effective phase.

## Test plan
- Reset then stream words 0x44332211, 0x88776655, 0xCCBBAA99, out_ready = 1 -> pixels (g,b,r) = (11,22,33),(44,55,66),(77,88,99),(AA,BB,CC); s_axis_tready low only during 4th pixel.
- Same 3 words, tuser on word 0, tlast on word 2 -> sof only on pixel 0, eol only on pixel 3.
- out_ready toggled 1/0 each cycle with tvalid random -> identical pixel sequence, no drops or duplicates, PH3 pixel held stable while stalled.
- tlast on word 1 (0x88776655) -> pixel (44,55,66) with eol = 1, err_short_line pulse, next word decoded as PH0.
- tuser on word 1 of a group -> err_sof_resync pulse, that word's lanes 0-2 emitted as pixel with sof = 1, phase continues from PH1.
- areset asserted in PH2 with residual loaded, then clean 3-word group -> first pixel from new group, no stale bytes.

Source files
------------

// File: rtl/axis_rgb_unpacker_pkg.sv
// Shared video constants: pixel-group phases, G,B,R byte-lane order and pixel width.
// Also used by the packer testbench so both ends agree on the lane layout.
package axis_rgb_unpacker_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_t;

    localparam logic [1:0] LANE_G = 2'd0;
    localparam logic [1:0] LANE_B = 2'd1;
    localparam logic [1:0] LANE_R = 2'd2;

    typedef struct packed {
        logic [PIX_W-1:0] g;
        logic [PIX_W-1:0] b;
        logic [PIX_W-1:0] r;
    } pixel_t;

    function automatic logic [PIX_W-1:0] lane(input logic [31:0] w, input logic [1:0] idx);
        return w[idx*PIX_W +: PIX_W];
    endfunction

endpackage

// File: rtl/axis_rgb_unpacker.sv
// Unpacks 3 x 32-bit words of G,B,R-ordered bytes into 4 pixels, one per beat.
// Phases 0-2 pass input straight through; phase 3 replays the 3 residual bytes.
module axis_rgb_unpacker
    import axis_rgb_unpacker_pkg::*;
(
    input  logic             aclk,
    input  logic             areset,
    input  logic [31:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic             s_axis_tlast,
    input  logic             s_axis_tuser,
    output logic [PIX_W-1:0] r,
    output logic [PIX_W-1:0] g,
    output logic [PIX_W-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sof,
    output logic             eol,
    output logic             err_short_line,
    output logic             err_sof_resync
);

    phase_t      phase;
    phase_t      eff;
    logic [23:0] res;
    logic        last_reg;
    pixel_t      pix;
    logic        eol_c;
    logic        xfer;

    // A start-of-frame word always restarts the group, whatever the phase register says.
    always_comb eff = (s_axis_tvalid && s_axis_tuser) ? PH0 : phase;

    always_comb begin
        pix   = '0;
        eol_c = 1'b0;
        case (eff)
            PH0: begin
                pix.g = lane(s_axis_tdata, LANE_G);
                pix.b = lane(s_axis_tdata, LANE_B);
                pix.r = lane(s_axis_tdata, LANE_R);
                eol_c = s_axis_tlast;
            end
            PH1: begin
                pix.g = res[7:0];
                pix.b = lane(s_axis_tdata, 2'd0);
                pix.r = lane(s_axis_tdata, 2'd1);
                eol_c = s_axis_tlast;
            end
            PH2: begin
                pix.g = res[7:0];
                pix.b = res[15:8];
                pix.r = lane(s_axis_tdata, 2'd0);
            end
            PH3: begin
                pix.g = res[7:0];
                pix.b = res[15:8];
                pix.r = res[23:16];
                eol_c = last_reg;
            end
        endcase
    end

    assign out_valid     = !areset && ((eff == PH3) || s_axis_tvalid);
    assign s_axis_tready = !areset && (eff != PH3) && out_ready;
    assign sof           = !areset && s_axis_tvalid && s_axis_tuser;
    assign eol           = out_valid && eol_c;
    assign xfer          = out_valid && out_ready;
    assign g             = pix.g;
    assign b             = pix.b;
    assign r             = pix.r;

    always_ff @(posedge aclk) begin
        if (areset) begin
            phase          <= PH0;
            res            <= '0;
            last_reg       <= 1'b0;
            err_short_line <= 1'b0;
            err_sof_resync <= 1'b0;
        end else begin
            err_short_line <= 1'b0;
            err_sof_resync <= xfer && s_axis_tvalid && s_axis_tuser && (phase != PH0);
            if (xfer) begin
                case (eff)
                    PH0: begin
                        last_reg <= 1'b0;
                        if (s_axis_tlast) begin
                            phase          <= PH0;
                            res            <= '0;
                            err_short_line <= 1'b1;
                        end else begin
                            phase <= PH1;
                            res   <= {16'h0, lane(s_axis_tdata, 2'd3)};
                        end
                    end
                    PH1: begin
                        if (s_axis_tlast) begin
                            phase          <= PH0;
                            res            <= '0;
                            last_reg       <= 1'b0;
                            err_short_line <= 1'b1;
                        end else begin
                            phase      <= PH2;
                            res[15:0]  <= s_axis_tdata[31:16];
                        end
                    end
                    PH2: begin
                        phase    <= PH3;
                        res      <= s_axis_tdata[31:8];
                        last_reg <= s_axis_tlast;
                    end
                    PH3: begin
                        phase    <= PH0;
                        last_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_rgb_unpacker.sv
// Directed bench for axis_rgb_unpacker: hand-computed pixels for each scenario.
module tb_axis_rgb_unpacker;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic [7:0]  r, g, b;
    logic        out_valid, out_ready, sof, eol, err_short_line, err_sof_resync;

    int checks = 0;
    int errors = 0;

    logic [31:0] w_a [3] = '{32'h44332211, 32'h88776655, 32'hCCBBAA99};
    logic [23:0] p_a [4] = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
    logic [31:0] w_n [3] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
    logic [23:0] p_n [4] = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};

    always #5 aclk = ~aclk;

    axis_rgb_unpacker dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser),
        .r(r), .g(g), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .sof(sof), .eol(eol),
        .err_short_line(err_short_line), .err_sof_resync(err_sof_resync)
    );

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic v, input logic u, input logic l);
        s_axis_tdata  = d;
        s_axis_tvalid = v;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
    endtask

    task automatic do_reset;
        areset = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        tick();
        areset = 1'b0;
    endtask

    task automatic test_reset;
        areset = 1'b1;
        out_ready = 1'b1;
        drive(32'hDEADBEEF, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        @(negedge aclk);
        checks++;
        if ({s_axis_tready, out_valid, sof, eol} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: tready/valid/sof/eol=%b expected 0000",
                     {s_axis_tready, out_valid, sof, eol});
        end
        tick();
        areset = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge aclk);
        checks++;
        if ({out_valid, err_short_line, err_sof_resync, s_axis_tready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_release: valid/errs/tready=%b expected 0001",
                     {out_valid, err_short_line, err_sof_resync, s_axis_tready});
        end
        tick();
    endtask

    task automatic test_basic;
        for (int k = 0; k < 4; k++) begin
            drive((k < 3) ? w_a[k] : w_a[0], 1'b1, 1'b0, 1'b0);
            @(negedge aclk);
            checks++;
            if ({out_valid, g, b, r} !== {1'b1, p_a[k]}) begin
                errors++;
                $display("FAIL basic_pix%0d: got v=%b gbr=%h expected v=1 gbr=%h",
                         k, out_valid, {g, b, r}, p_a[k]);
            end
            checks++;
            if ({s_axis_tready, sof, eol} !== {(k != 3), 2'b00}) begin
                errors++;
                $display("FAIL basic_ctl%0d: tready/sof/eol=%b expected %b",
                         k, {s_axis_tready, sof, eol}, {(k != 3), 2'b00});
            end
            tick();
        end
        drive(32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_flags;
        for (int k = 0; k < 4; k++) begin
            drive((k < 3) ? w_a[k] : 32'h0, (k < 3), (k == 0), (k == 2));
            @(negedge aclk);
            checks++;
            if ({out_valid, g, b, r, sof, eol} !== {1'b1, p_a[k], (k == 0), (k == 3)}) begin
                errors++;
                $display("FAIL flags_pix%0d: v=%b gbr=%h sof=%b eol=%b expected gbr=%h sof=%b eol=%b",
                         k, out_valid, {g, b, r}, sof, eol, p_a[k], (k == 0), (k == 3));
            end
            checks++;
            if ({err_short_line, err_sof_resync} !== 2'b00) begin
                errors++;
                $display("FAIL flags_err%0d: errs=%b expected 00", k, {err_short_line, err_sof_resync});
            end
            tick();
        end
        drive(32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stall;
        int          widx = 0;
        int          pidx = 0;
        logic        held = 1'b0;
        logic [23:0] held_pix = '0;
        for (int cyc = 0; cyc < 200 && pidx < 8; cyc++) begin
            out_ready = (cyc % 2 == 0);
            drive(w_a[widx % 3], 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            @(negedge aclk);
            if (held) begin
                checks++;
                if ({out_valid, g, b, r} !== {1'b1, held_pix}) begin
                    errors++;
                    $display("FAIL stall_hold: v=%b gbr=%h expected v=1 gbr=%h",
                             out_valid, {g, b, r}, held_pix);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if ({g, b, r} !== p_a[pidx % 4]) begin
                    errors++;
                    $display("FAIL stall_pix%0d: got %h expected %h", pidx, {g, b, r}, p_a[pidx % 4]);
                end
                pidx++;
            end
            held = out_valid && !out_ready && (pidx % 4 == 3);
            held_pix = p_a[3];
            if (s_axis_tvalid && s_axis_tready) widx++;
            tick();
        end
        checks++;
        if (pidx != 8 || widx != 6) begin
            errors++;
            $display("FAIL stall_count: pixels=%0d words=%0d expected 8 and 6", pidx, widx);
        end
        out_ready = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_short_line;
        do_reset();
        drive(w_a[0], 1'b1, 1'b0, 1'b0);
        tick();
        drive(w_a[1], 1'b1, 1'b0, 1'b1);
        @(negedge aclk);
        checks++;
        if ({out_valid, g, b, r, eol, err_short_line} !== {1'b1, 24'h445566, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL short_pix: v=%b gbr=%h eol=%b err=%b expected gbr=445566 eol=1 err=0",
                     out_valid, {g, b, r}, eol, err_short_line);
        end
        tick();
        drive(w_a[2], 1'b1, 1'b0, 1'b0);
        @(negedge aclk);
        checks++;
        if (err_short_line !== 1'b1) begin
            errors++;
            $display("FAIL short_err: err_short_line=%b expected 1", err_short_line);
        end
        checks++;
        if ({g, b, r, eol} !== {24'h99AABB, 1'b0}) begin
            errors++;
            $display("FAIL short_next: gbr=%h eol=%b expected 99aabb eol=0", {g, b, r}, eol);
        end
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge aclk);
        checks++;
        if (err_short_line !== 1'b0) begin
            errors++;
            $display("FAIL short_pulse: err_short_line=%b expected 0", err_short_line);
        end
        tick();
    endtask

    task automatic test_sof_resync;
        do_reset();
        drive(w_a[0], 1'b1, 1'b0, 1'b0);
        tick();
        drive(w_a[1], 1'b1, 1'b1, 1'b0);
        @(negedge aclk);
        checks++;
        if ({out_valid, s_axis_tready, g, b, r, sof, err_sof_resync} !== {2'b11, 24'h556677, 2'b10}) begin
            errors++;
            $display("FAIL resync_pix: v=%b rdy=%b gbr=%h sof=%b err=%b expected gbr=556677 sof=1 err=0",
                     out_valid, s_axis_tready, {g, b, r}, sof, err_sof_resync);
        end
        tick();
        drive(w_a[2], 1'b1, 1'b0, 1'b0);
        @(negedge aclk);
        checks++;
        if (err_sof_resync !== 1'b1) begin
            errors++;
            $display("FAIL resync_err: err_sof_resync=%b expected 1", err_sof_resync);
        end
        checks++;
        if ({g, b, r, sof} !== {24'h8899AA, 1'b0}) begin
            errors++;
            $display("FAIL resync_ph1: gbr=%h sof=%b expected 8899aa sof=0", {g, b, r}, sof);
        end
        tick();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge aclk);
        checks++;
        if (err_sof_resync !== 1'b0) begin
            errors++;
            $display("FAIL resync_pulse: err_sof_resync=%b expected 0", err_sof_resync);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        drive(w_a[0], 1'b1, 1'b0, 1'b0);
        tick();
        drive(w_a[1], 1'b1, 1'b0, 1'b0);
        tick();
        areset = 1'b1;
        drive(w_a[2], 1'b1, 1'b0, 1'b0);
        @(negedge aclk);
        checks++;
        if ({out_valid, s_axis_tready} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_hold: valid/tready=%b expected 00", {out_valid, s_axis_tready});
        end
        tick();
        areset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive((k < 3) ? w_n[k] : 32'h0, (k < 3), 1'b0, 1'b0);
            @(negedge aclk);
            checks++;
            if ({out_valid, g, b, r} !== {1'b1, p_n[k]}) begin
                errors++;
                $display("FAIL midreset_pix%0d: v=%b gbr=%h expected v=1 gbr=%h",
                         k, out_valid, {g, b, r}, p_n[k]);
            end
            tick();
        end
    endtask

    initial begin
        areset = 1'b1;
        out_ready = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_basic();
        test_flags();
        test_stall();
        test_short_line();
        test_sof_resync();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
